sam_controller: RTL and testbench



---
 rtl/sam_ctrl_pkg.sv | 55 +++++
 rtl/sam_ctrl_rom.sv | 45 ++++
 rtl/sam_controller.sv | 81 ++++++++
 tb/tb_sam_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sam_ctrl_pkg.sv
// Shared definitions for the SAM sequencer: state encoding, opcodes and control-word bit positions.
package sam_ctrl_pkg;

    localparam int CW_W = 22;

    typedef enum logic [4:0] {
        ST_RST   = 5'd0,
        ST_F0    = 5'd1,
        ST_F1    = 5'd2,
        ST_FW    = 5'd3,
        ST_FL    = 5'd4,
        ST_F3    = 5'd5,
        ST_DEC   = 5'd6,
        ST_RQ    = 5'd7,
        ST_RL    = 5'd8,
        ST_LD0   = 5'd9,
        ST_LD1   = 5'd10,
        ST_AD0   = 5'd11,
        ST_AD1   = 5'd12,
        ST_EXW   = 5'd13,
        ST_ST0   = 5'd14,
        ST_ST1   = 5'd15,
        ST_ST_WR = 5'd16,
        ST_BR    = 5'd17
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_BRN   = 2'b11;

    localparam int B_PC_ABUS    = 21;
    localparam int B_IR_ABUS    = 20;
    localparam int B_MBR_ABUS   = 19;
    localparam int B_RBUS_AC    = 18;
    localparam int B_AC_ALUA    = 17;
    localparam int B_MBUS_ALUB  = 16;
    localparam int B_ALU_ADD    = 15;
    localparam int B_ALU_PASSB  = 14;
    localparam int B_MAR_ADDR   = 13;
    localparam int B_MBR_DATA   = 12;
    localparam int B_ABUS_IR    = 11;
    localparam int B_ABUS_MAR   = 10;
    localparam int B_DATA_MBR   = 9;
    localparam int B_RBUS_MBR   = 8;
    localparam int B_MBR_MBUS   = 7;
    localparam int B_PC_ZERO    = 6;
    localparam int B_PC_INC     = 5;
    localparam int B_ABUS_PC    = 4;
    localparam int B_RW         = 3;
    localparam int B_REQUEST    = 2;
    localparam int B_AC_RBUS    = 1;
    localparam int B_ALU_RBUS   = 0;

endpackage

// File: rtl/sam_ctrl_rom.sv
// Combinational state -> control-word decoder for the SAM sequencer.
module sam_ctrl_rom
    import sam_ctrl_pkg::*;
(
    input  state_t            state,
    output logic [CW_W-1:0]   word
);

    always_comb begin
        // NOTE: default every bit first so no path through the case can infer a latch.
        word        = '0;
        word[B_RW]  = 1'b1;
        case (state)
            ST_F0:    begin word[B_PC_ABUS] = 1'b1; word[B_ABUS_MAR] = 1'b1; end
            ST_F1:    begin word[B_MAR_ADDR] = 1'b1; word[B_REQUEST] = 1'b1; word[B_PC_INC] = 1'b1; end
            ST_FW:    begin word[B_MAR_ADDR] = 1'b1; word[B_REQUEST] = 1'b1; end
            ST_FL:    word[B_DATA_MBR] = 1'b1;
            ST_F3:    begin word[B_MBR_ABUS] = 1'b1; word[B_ABUS_IR] = 1'b1; end
            ST_DEC:   begin word[B_IR_ABUS] = 1'b1; word[B_ABUS_MAR] = 1'b1; end
            ST_RQ:    begin word[B_MAR_ADDR] = 1'b1; word[B_REQUEST] = 1'b1; end
            ST_RL:    word[B_DATA_MBR] = 1'b1;
            ST_LD0:   begin word[B_MBR_MBUS] = 1'b1; word[B_MBUS_ALUB] = 1'b1; word[B_ALU_PASSB] = 1'b1; end
            ST_LD1:   begin word[B_ALU_PASSB] = 1'b1; word[B_ALU_RBUS] = 1'b1; end
            ST_AD0:   begin
                word[B_AC_ALUA]   = 1'b1;
                word[B_MBR_MBUS]  = 1'b1;
                word[B_MBUS_ALUB] = 1'b1;
                word[B_ALU_ADD]   = 1'b1;
            end
            ST_AD1:   begin word[B_ALU_ADD] = 1'b1; word[B_ALU_RBUS] = 1'b1; end
            ST_EXW:   word[B_RBUS_AC] = 1'b1;
            ST_ST0:   word[B_AC_RBUS] = 1'b1;
            ST_ST1:   word[B_RBUS_MBR] = 1'b1;
            ST_ST_WR: begin
                word[B_MAR_ADDR] = 1'b1;
                word[B_MBR_DATA] = 1'b1;
                word[B_REQUEST]  = 1'b1;
                word[B_RW]       = 1'b0;
            end
            ST_BR:    begin word[B_IR_ABUS] = 1'b1; word[B_ABUS_PC] = 1'b1; end
            default:  word[B_PC_ZERO] = 1'b1;
        endcase
    end

endmodule

// File: rtl/sam_controller.sv
// Moore sequencer for the SAM accumulator machine; b is registered and decoded from the next state.
// Optional debug port `state` is enabled by defining SAM_CTRL_STATE_OUT_EN.
module sam_controller
    import sam_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              WAIT,
    input  logic              ir15,
    input  logic              ac15,
    input  logic              ir14,
    output logic [CW_W-1:0]   b
`ifdef SAM_CTRL_STATE_OUT_EN
    ,
    output logic [4:0]        state
`endif
);

    state_t            state_q;
    state_t            next_state;
    state_t            rom_state;
    logic [CW_W-1:0]   rom_word;
    logic [1:0]        opcode;

    assign opcode = {ir15, ir14};

    always_comb begin
        next_state = ST_RST;
        case (state_q)
            ST_RST:   next_state = ST_F0;
            ST_F0:    next_state = ST_F1;
            ST_F1:    next_state = ST_FW;
            ST_FW:    next_state = WAIT ? ST_FW : ST_FL;
            ST_FL:    next_state = ST_F3;
            ST_F3:    next_state = ST_DEC;
            ST_DEC: begin
                case (opcode)
                    OP_STORE: next_state = ST_ST0;
                    OP_BRN:   next_state = ac15 ? ST_BR : ST_F0;
                    default:  next_state = ST_RQ;
                endcase
            end
            ST_RQ:    next_state = WAIT ? ST_RQ : ST_RL;
            // Only LOAD and ADD reach RL, so IR[15] alone separates them.
            ST_RL:    next_state = ir15 ? ST_AD0 : ST_LD0;
            ST_LD0:   next_state = ST_LD1;
            ST_LD1:   next_state = ST_EXW;
            ST_AD0:   next_state = ST_AD1;
            ST_AD1:   next_state = ST_EXW;
            ST_EXW:   next_state = ST_F0;
            ST_ST0:   next_state = ST_ST1;
            ST_ST1:   next_state = ST_ST_WR;
            ST_ST_WR: next_state = WAIT ? ST_ST_WR : ST_F0;
            ST_BR:    next_state = ST_F0;
            default:  next_state = ST_RST;
        endcase
    end

    // Decode the state being entered so b changes on the same edge as the state.
    assign rom_state = reset ? ST_RST : next_state;

    sam_ctrl_rom u_rom (
        .state (rom_state),
        .word  (rom_word)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q <= ST_RST;
        end else begin
            state_q <= next_state;
        end
        b <= rom_word;
    end

`ifdef SAM_CTRL_STATE_OUT_EN
    assign state = state_q;
`endif

endmodule

// File: tb/tb_sam_controller.sv
// Scoreboard bench for sam_controller: a driver queues the expected control word per edge, a monitor checks it.
module tb_sam_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        WAIT = 1'b0;
    logic        ir15 = 1'b0;
    logic        ac15 = 1'b0;
    logic        ir14 = 1'b0;
    logic [21:0] b;
`ifdef SAM_CTRL_STATE_OUT_EN
    logic [4:0]  dbg_state;
`endif

    sam_controller dut (
        .clk   (clk),
        .reset (reset),
        .WAIT  (WAIT),
        .ir15  (ir15),
        .ac15  (ac15),
        .ir14  (ir14),
        .b     (b)
`ifdef SAM_CTRL_STATE_OUT_EN
        ,
        .state (dbg_state)
`endif
    );

    always #5 clk = ~clk;

    // Expected words built from the control-bit table (RW = bit 3 set unless noted).
    localparam logic [21:0] W_RST  = 22'((1 << 6) | (1 << 3));
    localparam logic [21:0] W_F0   = 22'((1 << 21) | (1 << 10) | (1 << 3));
    localparam logic [21:0] W_F1   = 22'((1 << 13) | (1 << 2) | (1 << 5) | (1 << 3));
    localparam logic [21:0] W_FW   = 22'((1 << 13) | (1 << 2) | (1 << 3));
    localparam logic [21:0] W_FL   = 22'((1 << 9) | (1 << 3));
    localparam logic [21:0] W_F3   = 22'((1 << 19) | (1 << 11) | (1 << 3));
    localparam logic [21:0] W_DEC  = 22'((1 << 20) | (1 << 10) | (1 << 3));
    localparam logic [21:0] W_RQ   = 22'((1 << 13) | (1 << 2) | (1 << 3));
    localparam logic [21:0] W_RL   = 22'((1 << 9) | (1 << 3));
    localparam logic [21:0] W_LD0  = 22'((1 << 7) | (1 << 16) | (1 << 14) | (1 << 3));
    localparam logic [21:0] W_LD1  = 22'((1 << 14) | (1 << 0) | (1 << 3));
    localparam logic [21:0] W_AD0  = 22'((1 << 17) | (1 << 7) | (1 << 16) | (1 << 15) | (1 << 3));
    localparam logic [21:0] W_AD1  = 22'((1 << 15) | (1 << 0) | (1 << 3));
    localparam logic [21:0] W_EXW  = 22'((1 << 18) | (1 << 3));
    localparam logic [21:0] W_ST0  = 22'((1 << 1) | (1 << 3));
    localparam logic [21:0] W_ST1  = 22'((1 << 8) | (1 << 3));
    localparam logic [21:0] W_STWR = 22'((1 << 13) | (1 << 12) | (1 << 2));
    localparam logic [21:0] W_BR   = 22'((1 << 20) | (1 << 4) | (1 << 3));

    typedef struct {
        string       name;
        logic [21:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: each falling edge, the word latched on the previous rising edge is checked.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t t;
            t = sb.pop_front();
            n_cmp++;
            if (b !== t.word) begin
                n_bad++;
                $display("FAIL %s: b=%06h expected %06h at %0t", t.name, b, t.word, $time);
            end
        end
    end

    // Apply inputs for the coming rising edge and queue the word that edge must produce.
    task automatic step(input logic r, input logic w, input logic [1:0] op, input logic a,
                        input string nm, input logic [21:0] e);
        exp_t t;
        reset       = r;
        WAIT        = w;
        {ir15, ir14} = op;
        ac15        = a;
        t.name      = nm;
        t.word      = e;
        sb.push_back(t);
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch from F0 through DEC; noise drives WAIT and IR on edges that must ignore them.
    task automatic fetch(input logic noise);
        step(1'b0, noise, {noise, noise}, noise, "F1", W_F1);
        step(1'b0, 1'b0,  {noise, 1'b0},  noise, "FW", W_FW);
        step(1'b0, 1'b0,  2'b11,          noise, "FL", W_FL);
        step(1'b0, noise, 2'b11,          noise, "F3", W_F3);
        step(1'b0, noise, {1'b0, noise},  noise, "DEC", W_DEC);
    endtask

    initial begin
        // Reset held two cycles, then release into F0.
        step(1'b1, 1'b0, 2'b00, 1'b0, "reset0", W_RST);
        step(1'b1, 1'b1, 2'b11, 1'b1, "reset1", W_RST);
        step(1'b0, 1'b0, 2'b00, 1'b0, "F0_after_reset", W_F0);

        // LOAD with a 4-cycle FW stretch.
        step(1'b0, 1'b1, 2'b11, 1'b0, "ld_F1", W_F1);
        step(1'b0, 1'b1, 2'b11, 1'b0, "ld_FW0", W_FW);
        step(1'b0, 1'b1, 2'b11, 1'b0, "ld_FW1", W_FW);
        step(1'b0, 1'b1, 2'b11, 1'b0, "ld_FW2", W_FW);
        step(1'b0, 1'b1, 2'b11, 1'b0, "ld_FW3", W_FW);
        step(1'b0, 1'b0, 2'b11, 1'b0, "ld_FL", W_FL);
        step(1'b0, 1'b1, 2'b11, 1'b1, "ld_F3", W_F3);
        step(1'b0, 1'b1, 2'b01, 1'b1, "ld_DEC", W_DEC);
        step(1'b0, 1'b0, 2'b00, 1'b1, "ld_RQ", W_RQ);
        step(1'b0, 1'b1, 2'b00, 1'b0, "ld_RQ_wait", W_RQ);
        step(1'b0, 1'b0, 2'b11, 1'b0, "ld_RL", W_RL);
        step(1'b0, 1'b0, 2'b00, 1'b0, "ld_LD0", W_LD0);
        step(1'b0, 1'b1, 2'b10, 1'b0, "ld_LD1", W_LD1);
        step(1'b0, 1'b1, 2'b11, 1'b0, "ld_EXW", W_EXW);
        step(1'b0, 1'b1, 2'b01, 1'b0, "ld_F0", W_F0);

        // ADD, zero wait, with IR/WAIT noise on fetch edges.
        fetch(1'b1);
        step(1'b0, 1'b0, 2'b10, 1'b0, "add_RQ", W_RQ);
        step(1'b0, 1'b0, 2'b01, 1'b0, "add_RL", W_RL);
        step(1'b0, 1'b0, 2'b10, 1'b0, "add_AD0", W_AD0);
        step(1'b0, 1'b1, 2'b00, 1'b0, "add_AD1", W_AD1);
        step(1'b0, 1'b0, 2'b00, 1'b0, "add_EXW", W_EXW);
        step(1'b0, 1'b0, 2'b00, 1'b0, "add_F0", W_F0);

        // STORE with one extra ST_WR wait cycle.
        fetch(1'b0);
        step(1'b0, 1'b0, 2'b01, 1'b0, "st_ST0", W_ST0);
        step(1'b0, 1'b0, 2'b10, 1'b1, "st_ST1", W_ST1);
        step(1'b0, 1'b1, 2'b00, 1'b0, "st_STWR0", W_STWR);
        step(1'b0, 1'b1, 2'b00, 1'b0, "st_STWR1", W_STWR);
        step(1'b0, 1'b0, 2'b00, 1'b0, "st_F0", W_F0);

        // BRN taken, then BRN not taken.
        fetch(1'b0);
        step(1'b0, 1'b0, 2'b11, 1'b1, "brn_BR", W_BR);
        step(1'b0, 1'b0, 2'b11, 1'b1, "brn_F0", W_F0);
        fetch(1'b1);
        step(1'b0, 1'b1, 2'b11, 1'b0, "brn_nt_F0", W_F0);

        // ADD aborted by reset in AD1.
        fetch(1'b0);
        step(1'b0, 1'b0, 2'b10, 1'b0, "abrt_RQ", W_RQ);
        step(1'b0, 1'b0, 2'b10, 1'b0, "abrt_RL", W_RL);
        step(1'b0, 1'b0, 2'b10, 1'b0, "abrt_AD0", W_AD0);
        step(1'b0, 1'b0, 2'b10, 1'b0, "abrt_AD1", W_AD1);
        step(1'b1, 1'b0, 2'b10, 1'b0, "abrt_RST", W_RST);
        step(1'b0, 1'b0, 2'b00, 1'b0, "abrt_F0", W_F0);

        // Reset during a stalled fetch drops REQUEST on the next edge.
        step(1'b0, 1'b1, 2'b00, 1'b0, "midrst_F1", W_F1);
        step(1'b0, 1'b1, 2'b00, 1'b0, "midrst_FW", W_FW);
        step(1'b1, 1'b1, 2'b00, 1'b0, "midrst_RST", W_RST);
        step(1'b0, 1'b1, 2'b00, 1'b0, "midrst_F0", W_F0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
